// File: rtl/obstacle_sequencer.sv
// Obstacle sequencer: steps through obstacle codes (sequential or LFSR order),
// inserting idle gaps between obstacles and counting completed rounds toward a win.
module obstacle_sequencer #(
  parameter int NUM_BITS      = 3,
  parameter int NUM_OBSTACLES = 8,
  parameter int GAP_CYCLES    = 32,
  parameter int GAP_WIDTH     = 26,
  parameter int ROUNDS        = 3,
  parameter int RANDOM        = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done,
  input  logic                play_selected,
  output logic [NUM_BITS-1:0] obstacle_code,
  output logic                obstacle_active,
  output logic                done_out,
  output logic [7:0]          round_count,
  output logic                victory
);

  localparam int CNT_W = NUM_BITS + 1;
  localparam logic [NUM_BITS-1:0]  LAST_CODE  = NUM_BITS'(NUM_OBSTACLES - 1);
  localparam logic [CNT_W-1:0]     ROUND_LEN  = CNT_W'(NUM_OBSTACLES);
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD   = (GAP_CYCLES == 0) ? '0 : GAP_WIDTH'(GAP_CYCLES - 1);
  localparam logic [7:0]           ROUNDS_WIN = 8'(ROUNDS);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, WIN} state_t;

  state_t               state, state_next;
  logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_next;
  logic [CNT_W-1:0]     obs_cnt, obs_cnt_next, obs_inc;
  logic [NUM_BITS-1:0]  code_next, cand, first_code, step_code;
  logic [7:0]           rounds_next, rounds_inc;
  logic [7:0]           lfsr;
  logic                 armed, accept, round_done;
  logic                 active_next, victory_next;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [NUM_BITS-1:0] wrap_inc(input logic [NUM_BITS-1:0] c);
    return (c == LAST_CODE) ? '0 : c + NUM_BITS'(1);
  endfunction

  // Folds the low LFSR bits into 0..NUM_OBSTACLES-1; one subtraction suffices
  // because NUM_OBSTACLES exceeds half the code space.
  function automatic logic [NUM_BITS-1:0] fold(input logic [7:0] l);
    logic [CNT_W-1:0] raw;
    raw = {1'b0, l[NUM_BITS-1:0]};
    if (raw >= ROUND_LEN) raw = raw - ROUND_LEN;
    return raw[NUM_BITS-1:0];
  endfunction

  // A held done is accepted only once; it must drop before another is taken.
  assign accept     = (state == ACTIVE) && play_selected && done && armed;
  assign obs_inc    = obs_cnt + CNT_W'(1);
  assign round_done = (obs_inc == ROUND_LEN);
  assign rounds_inc = sat_inc8(round_count);
  assign cand       = fold(lfsr);
  assign first_code = (RANDOM != 0) ? cand : '0;
  assign step_code  = (RANDOM == 0) ? wrap_inc(obstacle_code) :
                      (cand == obstacle_code) ? wrap_inc(obstacle_code) : cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      obs_cnt       <= '0;
      obstacle_code <= '0;
      round_count   <= '0;
      obstacle_active <= 1'b0;
      victory       <= 1'b0;
      done_out      <= 1'b0;
      armed         <= 1'b1;
      lfsr          <= 8'hA5;
    end else begin
      state         <= state_next;
      gap_cnt       <= gap_cnt_next;
      obs_cnt       <= obs_cnt_next;
      obstacle_code <= code_next;
      round_count   <= rounds_next;
      obstacle_active <= active_next;
      victory       <= victory_next;
      done_out      <= accept;
      if (accept)     armed <= 1'b0;
      else if (!done) armed <= 1'b1;
      lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    obs_cnt_next = obs_cnt;
    code_next    = obstacle_code;
    rounds_next  = round_count;
    if (!play_selected) begin
      state_next   = IDLE;
      gap_cnt_next = '0;
      obs_cnt_next = '0;
      code_next    = '0;
      rounds_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next   = ACTIVE;
          code_next    = first_code;
          obs_cnt_next = '0;
          rounds_next  = '0;
          gap_cnt_next = '0;
        end
        ACTIVE: begin
          if (accept) begin
            if (round_done) begin
              obs_cnt_next = '0;
              rounds_next  = rounds_inc;
            end else begin
              obs_cnt_next = obs_inc;
            end
            if (round_done && (ROUNDS != 0) && (rounds_inc == ROUNDS_WIN)) begin
              state_next = WIN;
            end else if (GAP_CYCLES == 0) begin
              state_next = ACTIVE;
              code_next  = step_code;
            end else begin
              state_next   = GAP;
              gap_cnt_next = GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state_next = ACTIVE;
            code_next  = step_code;
          end else begin
            gap_cnt_next = gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    active_next  = (state_next == ACTIVE);
    victory_next = (state_next == WIN);
  end

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Bench for obstacle_sequencer: a sequential-order instance with gaps and a win
// condition, plus a random-order gapless instance checked against an LFSR model.
module tb_obstacle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, done_a, play_a, done_b, play_b;
  logic [2:0] code_a, code_b;
  logic       act_a, act_b, dout_a, dout_b, vic_a, vic_b;
  logic [7:0] rnd_a, rnd_b;

  int vectors = 0;
  int errs    = 0;
  int n_a     = 0;

  logic [7:0] m_lfsr, m_lfsr_pre;

  obstacle_sequencer #(.NUM_BITS(3), .NUM_OBSTACLES(8), .GAP_CYCLES(4), .GAP_WIDTH(26),
                       .ROUNDS(2), .RANDOM(0)) dut_a (
    .clk(clk), .rst(rst), .done(done_a), .play_selected(play_a),
    .obstacle_code(code_a), .obstacle_active(act_a), .done_out(dout_a),
    .round_count(rnd_a), .victory(vic_a));

  obstacle_sequencer #(.NUM_BITS(3), .NUM_OBSTACLES(6), .GAP_CYCLES(0), .GAP_WIDTH(26),
                       .ROUNDS(0), .RANDOM(1)) dut_b (
    .clk(clk), .rst(rst), .done(done_b), .play_selected(play_b),
    .obstacle_code(code_b), .obstacle_active(act_b), .done_out(dout_b),
    .round_count(rnd_b), .victory(vic_b));

  // Reference LFSR for x^8+x^6+x^5+x^4+1; keeps the value seen at each edge.
  always @(posedge clk) begin
    m_lfsr_pre = m_lfsr;
    if (rst) m_lfsr = 8'hA5;
    else     m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input int code, input int act, input int dout,
                         input int rnd, input int vic);
    chk({tag, ".code"}, 32'(code_a), code);
    chk({tag, ".active"}, 32'(act_a), act);
    chk({tag, ".done_out"}, 32'(dout_a), dout);
    chk({tag, ".round"}, 32'(rnd_a), rnd);
    chk({tag, ".victory"}, 32'(vic_a), vic);
  endtask

  // One obstacle on instance A: pre idle cycles, then done held w cycles.
  task automatic obstacle_a(input int w, input int pre);
    int win;
    done_a = 1'b0;
    repeat (pre) begin
      step();
      check_a("seq_active", n_a % 8, 1, 0, n_a / 8, 0);
    end
    done_a = 1'b1;
    step();
    n_a++;
    win = (n_a == 16) ? 1 : 0;
    for (int g = 0; g < 4; g++) begin
      check_a(win ? "seq_win" : "seq_gap", (n_a - 1) % 8, 0, (g == 0) ? 1 : 0,
              win ? 2 : n_a / 8, win);
      done_a = (g < w - 1) ? 1'b1 : 1'b0;
      step();
    end
    if (win == 0) check_a("seq_next", n_a % 8, 1, 0, n_a / 8, 0);
  endtask

  initial begin
    int pulses, prev_b, exp_b, cand, n_b;
    rst = 1'b1; play_a = 1'b0; play_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
    repeat (2) step();
    check_a("reset", 0, 0, 0, 0, 0);
    chk("reset_b.code", 32'(code_b), 0);
    chk("reset_b.active", 32'(act_b), 0);
    chk("reset_b.round", 32'(rnd_b), 0);

    rst = 1'b0;
    step();
    check_a("idle_hold", 0, 0, 0, 0, 0);

    play_a = 1'b1;
    step();
    check_a("start", 0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) obstacle_a($urandom_range(1, 3), $urandom_range(0, 3));

    for (int i = 0; i < 4; i++) begin
      done_a = i[0];
      step();
      check_a("win_hold", 7, 0, 0, 2, 1);
    end
    done_a = 1'b0;

    play_a = 1'b0;
    step();
    check_a("abort_win", 0, 0, 0, 0, 0);
    n_a = 0;
    play_a = 1'b1;
    step();
    check_a("restart", 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) obstacle_a(1, 0);
    play_a = 1'b0;
    done_a = 1'b1;
    step();
    check_a("abort_done", 0, 0, 0, 0, 0);
    done_a = 1'b0;
    play_a = 1'b1;
    step();
    check_a("abort_restart", 0, 1, 0, 0, 0);
    n_a = 0;

    done_a = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(dout_a);
    end
    done_a = 1'b0;
    chk("held.pulses", 32'(pulses), 1);
    chk("held.code", 32'(code_a), 1);
    chk("held.active", 32'(act_a), 1);
    step();
    check_a("held_release", 1, 1, 0, 0, 0);

    done_a = 1'b1;
    step();
    done_a = 1'b0;
    step();
    check_a("gap_mid", 1, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    check_a("reset_gap", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    check_a("reset_restart", 0, 1, 0, 0, 0);
    play_a = 1'b0;

    play_b = 1'b1;
    step();
    exp_b = int'(m_lfsr_pre[2:0]) % 6;
    chk("rand_first.code", 32'(code_b), exp_b);
    chk("rand_first.active", 32'(act_b), 1);
    prev_b = exp_b;
    n_b = 0;
    for (int i = 0; i < 200; i++) begin
      done_b = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        step();
        chk("rand_idle.code", 32'(code_b), prev_b);
        chk("rand_idle.done_out", 32'(dout_b), 0);
      end
      done_b = 1'b1;
      step();
      n_b++;
      cand  = int'(m_lfsr_pre[2:0]) % 6;
      exp_b = (cand == prev_b) ? (prev_b + 1) % 6 : cand;
      chk("rand.code", 32'(code_b), exp_b);
      chk("rand.in_range", 32'(code_b < 3'd6), 1);
      chk("rand.no_repeat", 32'(int'(code_b) != prev_b), 1);
      chk("rand.active", 32'(act_b), 1);
      chk("rand.done_out", 32'(dout_b), 1);
      chk("rand.round", 32'(rnd_b), n_b / 6);
      prev_b = exp_b;
    end
    done_b = 1'b0;
    step();
    chk("rand_end.victory", 32'(vic_b), 0);
    chk("rand_end.done_out", 32'(dout_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
